// File: rtl/spi_slave_if.sv
// Parallel tx/rx handshake between host logic and spi_slave.
// The slave modport is the spi_slave side; master is the host side.
interface spi_slave_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
  modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/spi_slave.sv
// SPI slave, all four CPOL/CPHA modes, pins oversampled on clk, one-deep tx holding register.
// Optional sticky tx_underrun flag is built when SPI_SLAVE_ERR_EN is defined.
module spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CPOL,
  input  logic       CPHA,
  spi_slave_if.slave bus,
  output logic       busy,
  input  logic       err_clr,
  output logic       tx_underrun,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       SS_n,
  output logic       MISO,
  output logic       MISO_oe
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic                   sclk_d;
  logic                   sclk_s, mosi_s, ss_s;
  logic                   rise, fall, lead_ev, trail_ev, sample_ev, shift_ev;
  logic                   cpol_q, cpha_q;
  logic [2:0]             bit_cnt;
  logic                   byte_done;
  logic [7:0]             rx_shift, tx_shift, hold_data, load_byte;
  logic                   hold_full;
  logic                   in_frame, frame_start, load, tx_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      sclk_d    <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_d;
  assign fall      = ~sclk_s & sclk_d;
  assign lead_ev   = cpol_q ? fall : rise;
  assign trail_ev  = cpol_q ? rise : fall;
  assign sample_ev = cpha_q ? trail_ev : lead_ev;
  assign shift_ev  = cpha_q ? lead_ev : trail_ev;

  assign in_frame    = (state == ACTIVE) && !ss_s;
  assign frame_start = (state == IDLE) && !ss_s;
  // A shift edge at bit 0 only reloads once a byte has finished; in CPHA=1 the
  // very first leading edge lands here too and must leave the preloaded byte alone.
  assign load      = frame_start || (in_frame && shift_ev && (bit_cnt == 3'd0) && byte_done);
  assign load_byte = hold_full ? hold_data : IDLE_FILL;
  assign tx_write  = bus.tx_valid && !hold_full;

  assign bus.tx_ready = !hold_full;
  assign busy         = !ss_s;
  assign MISO_oe      = busy;
  assign MISO         = tx_shift[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      bit_cnt      <= 3'd0;
      byte_done    <= 1'b0;
      rx_shift     <= 8'h00;
      tx_shift     <= 8'h00;
      hold_data    <= 8'h00;
      hold_full    <= 1'b0;
      bus.rx_data  <= 8'h00;
      bus.rx_valid <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      // Load and write are exclusive on hold_full, so a same-cycle write stays queued.
      if (load) begin
        tx_shift  <= load_byte;
        hold_full <= 1'b0;
      end
      if (tx_write) begin
        hold_data <= bus.tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (!ss_s) begin
            state     <= ACTIVE;
            cpol_q    <= CPOL;
            cpha_q    <= CPHA;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
          end
        end
        ACTIVE: begin
          if (ss_s) begin
            state <= IDLE;
          end else begin
            if (sample_ev) begin
              rx_shift <= {rx_shift[6:0], mosi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                bus.rx_data  <= {rx_shift[6:0], mosi_s};
                bus.rx_valid <= 1'b1;
                byte_done    <= 1'b1;
              end
            end
            if (shift_ev && (bit_cnt != 3'd0))
              tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tx_underrun <= 1'b0;
    else if (load && !hold_full)
      tx_underrun <= 1'b1;
    else if (err_clr)
      tx_underrun <= 1'b0;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign tx_underrun    = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: the bench plays the SPI master and the host side of the handshake.
module tb_spi_slave;
  localparam int         HALF = 20;
  localparam logic [7:0] FILL = 8'h00;
`ifdef SPI_SLAVE_ERR_EN
  localparam logic EXP_UR = 1'b1;
`else
  localparam logic EXP_UR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic CPOL = 1'b0, CPHA = 1'b0, SCLK = 1'b0, MOSI = 1'b0, SS_n = 1'b1, err_clr = 1'b0;
  logic busy, tx_underrun, MISO, MISO_oe;
  logic cpol_v = 1'b0, cpha_v = 1'b0;
  int n_cmp = 0, n_bad = 0, rx_cnt = 0;
  logic [7:0] rx_log [0:15];
  logic [7:0] rx_last = 8'h00;

  spi_slave_if bus();

  spi_slave #(.SYNC_STAGES(2), .IDLE_FILL(FILL)) dut (
    .clk(clk), .rst_n(rst_n), .CPOL(CPOL), .CPHA(CPHA), .bus(bus), .busy(busy),
    .err_clr(err_clr), .tx_underrun(tx_underrun), .SCLK(SCLK), .MOSI(MOSI),
    .SS_n(SS_n), .MISO(MISO), .MISO_oe(MISO_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_log[rx_cnt % 16] = bus.rx_data;
      rx_last = bus.rx_data;
      rx_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic queue_byte(input logic [7:0] d);
    int n = 0;
    while (!bus.tx_ready && n < 3000) begin
      wait_clk(1);
      n++;
    end
    n_cmp++;
    if (bus.tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL queue_wait: tx_ready=%b required 1", bus.tx_ready);
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    wait_clk(1);
    bus.tx_valid = 1'b0;
    n_cmp++;
    if (bus.tx_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL queue_take: tx_ready=%b required 0", bus.tx_ready);
    end
  endtask

  task automatic frame_begin(input logic pol, input logic pha);
    cpol_v = pol; cpha_v = pha;
    CPOL = pol; CPHA = pha; SCLK = pol;
    wait_clk(8);
    SS_n = 1'b0;
    wait_clk(HALF);
    CPOL = ~pol; CPHA = ~pha;   // must not disturb the latched mode
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    SS_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic spi_bits(input logic [7:0] m, input int nb, output logic [7:0] s);
    s = 8'h00;
    for (int i = 0; i < nb; i++) begin
      if (!cpha_v) MOSI = m[7-i];
      wait_clk(HALF);
      SCLK = ~cpol_v;
      if (cpha_v) MOSI = m[7-i];
      else s = {s[6:0], MISO};
      wait_clk(HALF);
      SCLK = cpol_v;
      if (cpha_v) s = {s[6:0], MISO};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(2);
    n_cmp++;
    if ({bus.tx_ready, bus.rx_data, bus.rx_valid, busy, MISO, MISO_oe, tx_underrun} !== {1'b1, 8'h00, 5'b0}) begin
      n_bad++;
      $display("FAIL reset_values: got %b required %b",
               {bus.tx_ready, bus.rx_data, bus.rx_valid, busy, MISO, MISO_oe, tx_underrun}, {1'b1, 8'h00, 5'b0});
    end
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_single(input logic pol, input logic pha, input logic [7:0] slv, input logic [7:0] mst);
    int c0;
    logic [7:0] s;
    queue_byte(slv);
    c0 = rx_cnt;
    frame_begin(pol, pha);
    n_cmp++;
    if ({busy, MISO_oe} !== 2'b11) begin
      n_bad++; $display("FAIL busy_in_frame: got %b required 11", {busy, MISO_oe});
    end
    spi_bits(mst, 8, s);
    frame_end();
    n_cmp++;
    if (rx_cnt - c0 != 1) begin
      n_bad++; $display("FAIL single_pulses mode%0d: got %0d required 1", {pol, pha}, rx_cnt - c0);
    end
    n_cmp++;
    if (rx_last !== mst) begin
      n_bad++; $display("FAIL single_rx mode%0d: got %h required %h", {pol, pha}, rx_last, mst);
    end
    n_cmp++;
    if (s !== slv) begin
      n_bad++; $display("FAIL single_miso mode%0d: got %h required %h", {pol, pha}, s, slv);
    end
    n_cmp++;
    if ({busy, MISO_oe} !== 2'b00) begin
      n_bad++; $display("FAIL busy_after_frame: got %b required 00", {busy, MISO_oe});
    end
  endtask

  task automatic test_back_to_back(input logic pol, input logic pha);
    int c0;
    logic [7:0] s0, s1;
    queue_byte(8'h11);
    c0 = rx_cnt;
    fork
      begin
        frame_begin(pol, pha);
        spi_bits(8'hF0, 8, s0);
        spi_bits(8'h0F, 8, s1);
        frame_end();
      end
      queue_byte(8'h22);
    join
    n_cmp++;
    if (rx_cnt - c0 != 2) begin
      n_bad++; $display("FAIL b2b_pulses mode%0d: got %0d required 2", {pol, pha}, rx_cnt - c0);
    end
    n_cmp++;
    if ({rx_log[c0 % 16], rx_log[(c0 + 1) % 16]} !== 16'hF00F) begin
      n_bad++; $display("FAIL b2b_rx mode%0d: got %h %h required f0 0f", {pol, pha}, rx_log[c0 % 16], rx_log[(c0 + 1) % 16]);
    end
    n_cmp++;
    if ({s0, s1} !== 16'h1122) begin
      n_bad++; $display("FAIL b2b_miso mode%0d: got %h %h required 11 22", {pol, pha}, s0, s1);
    end
  endtask

  task automatic test_underrun();
    int c0;
    logic [7:0] s0, s1;
    err_clr = 1'b1; wait_clk(1); err_clr = 1'b0; wait_clk(1);
    n_cmp++;
    if (tx_underrun !== 1'b0) begin
      n_bad++; $display("FAIL underrun_clear0: got %b required 0", tx_underrun);
    end
    queue_byte(8'h77);
    c0 = rx_cnt;
    frame_begin(1'b0, 1'b1);
    spi_bits(8'h12, 8, s0);
    spi_bits(8'h34, 8, s1);
    frame_end();
    n_cmp++;
    if ({s0, s1} !== {8'h77, FILL}) begin
      n_bad++; $display("FAIL underrun_miso: got %h %h required 77 %h", s0, s1, FILL);
    end
    n_cmp++;
    if ({rx_log[c0 % 16], rx_log[(c0 + 1) % 16]} !== 16'h1234) begin
      n_bad++; $display("FAIL underrun_rx: got %h %h required 12 34", rx_log[c0 % 16], rx_log[(c0 + 1) % 16]);
    end
    n_cmp++;
    if (tx_underrun !== EXP_UR) begin
      n_bad++; $display("FAIL underrun_flag: got %b required %b", tx_underrun, EXP_UR);
    end
    err_clr = 1'b1; wait_clk(1); err_clr = 1'b0; wait_clk(1);
    n_cmp++;
    if (tx_underrun !== 1'b0) begin
      n_bad++; $display("FAIL underrun_clear: got %b required 0", tx_underrun);
    end
  endtask

  task automatic test_abort();
    int c0;
    logic [7:0] s;
    c0 = rx_cnt;
    frame_begin(1'b0, 1'b0);
    spi_bits(8'hFF, 5, s);
    SS_n = 1'b1;
    wait_clk(8);
    n_cmp++;
    if (rx_cnt != c0) begin
      n_bad++; $display("FAIL abort_no_pulse: got %0d pulses required 0", rx_cnt - c0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_busy: got %b required 0", busy);
    end
    frame_begin(1'b0, 1'b0);
    spi_bits(8'h96, 8, s);
    frame_end();
    n_cmp++;
    if (rx_cnt - c0 != 1 || rx_last !== 8'h96) begin
      n_bad++; $display("FAIL abort_next_rx: got %0d pulses data %h required 1 pulse data 96", rx_cnt - c0, rx_last);
    end
    n_cmp++;
    if (s !== FILL) begin
      n_bad++; $display("FAIL abort_next_miso: got %h required %h", s, FILL);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] s;
    queue_byte(8'hE7);
    frame_begin(1'b0, 1'b0);
    spi_bits(8'hAA, 3, s);
    queue_byte(8'h5C);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.tx_ready, bus.rx_data, bus.rx_valid, busy, MISO, MISO_oe, tx_underrun} !== {1'b1, 8'h00, 5'b0}) begin
      n_bad++;
      $display("FAIL midreset_values: got %b required %b",
               {bus.tx_ready, bus.rx_data, bus.rx_valid, busy, MISO, MISO_oe, tx_underrun}, {1'b1, 8'h00, 5'b0});
    end
    SS_n = 1'b1; MOSI = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    test_single(1'b0, 1'b0, 8'h3C, 8'h69);
  endtask

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    test_reset();
    test_single(1'b0, 1'b0, 8'hA5, 8'h3C);
    test_single(1'b1, 1'b1, 8'h5A, 8'hC3);
    test_back_to_back(1'b0, 1'b1);
    test_back_to_back(1'b1, 1'b0);
    test_underrun();
    test_abort();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave endpoint that consumes the `SCLK`/`MOSI` stream produced by `spi_master` and returns `MISO`. All SPI pins are oversampled in the system clock domain. It supports all four CPOL/CPHA modes and multi-byte frames delimited by `SS_n`. Received bytes go to a parallel `rx_data`/`rx_valid` interface; transmit bytes come from a one-deep holding register filled by a valid/ready handshake.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `SCLK`, `MOSI` and `SS_n`; legal range 2–3.
- `IDLE_FILL`, default 8'h00: byte shifted out when no transmit byte is queued.
- `clk` input 1: system clock. One clock; all logic on `posedge clk`.
- `rst_n` input 1: asynchronous, active-low reset.
- `CPOL` input 1: clock polarity; latched at frame start.
- `CPHA` input 1: clock phase; latched at frame start.
- `tx_data` input 8: next byte to transmit.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: holding register empty.
- `rx_data` output 8: last complete received byte. Held until the next byte completes.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `busy` output 1: frame active (synchronized `SS_n` low).
- `err_clr` input 1: clears `tx_underrun`.
- `tx_underrun` output 1: sticky underrun flag.
- `SCLK` input 1: SPI clock from the master.
- `MOSI` input 1: SPI data in, MSB first.
- `SS_n` input 1: active-low slave select.
- `MISO` output 1: SPI data out, MSB first.
- `MISO_oe` output 1: output enable; high only while `busy`.

## Operation
- **Input conditioning**
  - `SCLK`, `MOSI` and `SS_n` pass through `SYNC_STAGES` flops.
  - Synchronizer reset values: `SS_n` = 1, the others 0.
  - One further `SCLK` flop provides rise/fall edge detection.
- **Edge definitions**
  - Leading edge = rise if `CPOL`=0, fall if `CPOL`=1. The trailing edge is the opposite.
  - Sample edge = leading if `CPHA`=0, trailing if `CPHA`=1. Shift edge = the other one.
- **States**
  - IDLE → ACTIVE on synchronized `SS_n` falling:
    - latch `CPOL`/`CPHA`;
    - `bit_cnt`=0;
    - load the tx shift register from the holding register if full (consumes it), else load `IDLE_FILL`.
  - ACTIVE → IDLE on synchronized `SS_n` high, from any bit position.
  - SCLK edges are ignored in IDLE.
- **Sample edge**
  - `rx_shift` ← {`rx_shift`[6:0], `MOSI_s`}; `bit_cnt`++ (3-bit, wraps 7→0).
  - On the 8th sample, `rx_data` ← the assembled byte and `rx_valid` pulses for exactly 1 cycle.
- **Shift edge**
  - If `bit_cnt`≠0: shift the tx register left.
  - If `bit_cnt`=0 and at least one byte has completed in this frame: load the next byte using the same rule as frame start.
  - If `bit_cnt`=0 and no byte has completed yet (CPHA=1 first leading edge): no action.
- **MISO**: `MISO` = tx shift register [7]. `MISO_oe` = `busy`.
- **Holding register**
  - `tx_ready` = !full. A write happens when `tx_valid` && `tx_ready`.
  - If a write and a load occur in the same cycle with the register empty, the load uses `IDLE_FILL` and the written byte stays queued.
- **Abort**: `SS_n` deasserting mid-byte discards the partial rx bits (no `rx_valid`). Any tx byte already loaded is consumed, not restored.

## Timing
- **Reset values**: `tx_ready`=1, `rx_data`=8'h00, `rx_valid`=0, `busy`=0, `MISO`=0, `MISO_oe`=0, `tx_underrun`=0. Holding register empty. State IDLE.
- **Pin-edge to internal-event latency**: `SYNC_STAGES`+1 clk.
- **MISO update**: `MISO` updates 1 clk after the internal shift-edge event.
- **rx_valid**: asserts 1 clk after the 8th internal sample event.
- **Clock-ratio requirement**: SCLK half-period ≥ 2×(`SYNC_STAGES`+2) clk. `spi_master` provides 50 clk.
- **busy**: asserts `SYNC_STAGES` clk after `SS_n` falls and deasserts `SYNC_STAGES` clk after it rises.
- **Mode stability**: `CPOL`/`CPHA` changes while `busy` have no effect until the next frame.
- **Mid-operation reset**: `rst_n` low returns all outputs to reset values immediately (asynchronously).

## Configuration
- **With `SPI_SLAVE_ERR_EN` defined**:
  - Any byte load that finds the holding register empty sets `tx_underrun`.
  - `err_clr` clears it on the next clk.
  - If set and clear occur in the same cycle, set wins.
- **Without `SPI_SLAVE_ERR_EN`**: `tx_underrun` is tied 0 and `err_clr` is ignored. All other behaviour is identical.

## Test plan
- **Mode 0, single byte**: queue 8'hA5; master sends 8'h3C.
  - `rx_data`=8'h3C with one `rx_valid` pulse.
  - Master receives 8'hA5.
- **Mode 3 (CPOL=1, CPHA=1)**: queue 8'h5A; master sends 8'hC3.
  - `rx_data`=8'hC3.
  - Master receives 8'h5A.
  - `SCLK` idles high without spurious samples.
- **Modes 1 and 2, two-byte frame**: queue 8'h11, then 8'h22 after `tx_ready` rises; master sends 8'hF0, 8'h0F.
  - Two `rx_valid` pulses with 8'hF0 then 8'h0F.
  - Master receives 8'h11, 8'h22.
- **Underrun**: two-byte frame with only 8'h77 queued.
  - Second MISO byte is 8'h00.
  - `tx_underrun`=1 with `SPI_SLAVE_ERR_EN` (0 without); `err_clr` pulse clears it.
- **Abort**: `SS_n` raised after 5 bits.
  - No `rx_valid`; `busy`=0.
  - Following full frame receives 8'h96 correctly.
- **Mid-operation reset**: `rst_n` pulsed low mid-byte.
  - All outputs at reset values.
  - Next frame receives correctly.
